// File: rtl/mc_controller_ext_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// The controller side (master) reads the instruction fields and status
// flags and drives every mux select and register enable.
interface mc_controller_ext_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       memreq;
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       immzext;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucont;
    logic       fault;
    logic [1:0] fault_code;
    logic [3:0] state_o;

    modport master (
        input  op, funct, zero, mem_ready,
        output memreq, pcen, memwrite, irwrite, regwrite, alusrca, iord,
               memtoreg, regdst, immzext, alusrcb, pcsrc, alucont,
               fault, fault_code, state_o
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  memreq, pcen, memwrite, irwrite, regwrite, alusrca, iord,
               memtoreg, regdst, immzext, alusrcb, pcsrc, alucont,
               fault, fault_code, state_o
    );
endinterface

// File: rtl/mc_controller_ext.sv
// Multicycle MIPS control unit: main FSM, ALU decode, memory wait states
// with a bounded timeout, and a sticky trap state that only reset leaves.
module mc_controller_ext #(
    parameter int MEM_WAIT = 1,
    parameter int WAIT_MAX = 15,
    parameter int EXT_OPS  = 1
) (
    input  logic                clk,
    input  logic                reset,
    mc_controller_ext_if.master bus
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_RTYPEWB = 4'd7;
    localparam logic [3:0] S_BEQEX   = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JEX     = 4'd11;
    localparam logic [3:0] S_BNEEX   = 4'd12;
    localparam logic [3:0] S_IMMEX   = 4'd13;
    localparam logic [3:0] S_TRAP    = 4'd14;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILL_OP  = 2'b01;
    localparam logic [1:0] FC_ILL_FN  = 2'b10;
    localparam logic [1:0] FC_TIMEOUT = 2'b11;

    localparam logic EXT_EN  = (EXT_OPS != 0);
    localparam logic WAIT_EN = (MEM_WAIT != 0);
    localparam logic TO_EN   = (WAIT_MAX > 0);

    // Counter only needs to reach WAIT_MAX; it saturates there.
    localparam int             CNT_W    = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LIM = (WAIT_MAX > 0) ? CNT_W'(WAIT_MAX) : '0;

    // ALU operation for an R-type funct; unknown functs fall back to AND
    // (they trap before any write-back anyway).
    function automatic logic [2:0] alu_from_funct(input logic [5:0] fn);
        logic [2:0] res;
        case (fn)
            6'b100000: res = ALU_ADD;
            6'b100010: res = ALU_SUB;
            6'b100100: res = ALU_AND;
            6'b100101: res = ALU_OR;
            6'b101010: res = ALU_SLT;
            default:   res = ALU_AND;
        endcase
        return res;
    endfunction

    function automatic logic funct_legal(input logic [5:0] fn);
        logic res;
        case (fn)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]       fault_code_q, fault_code_d;
    logic [1:0]       trap_code_s;
    logic             ready_s;
    logic             wait_state_s;
    logic             timeout_s;
    logic             imm_logic_s;

    assign ready_s      = WAIT_EN ? bus.mem_ready : 1'b1;
    assign wait_state_s = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timeout_s    = TO_EN && wait_state_s && !ready_s && (wait_cnt_q == WAIT_LIM);
    assign imm_logic_s  = (bus.op == OP_ANDI) || (bus.op == OP_ORI);

    // State, wait counter and latched fault cause.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_FETCH;
            wait_cnt_q   <= '0;
            fault_code_q <= FC_NONE;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            fault_code_q <= fault_code_d;
        end
    end

    // Next state, trap cause, wait counter and fault code update.
    always_comb begin
        state_d     = state_q;
        trap_code_s = FC_NONE;
        if (timeout_s) begin
            state_d     = S_TRAP;
            trap_code_s = FC_TIMEOUT;
        end else begin
            case (state_q)
                S_FETCH:   state_d = ready_s ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (bus.op)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = (bus.funct == 6'b000000) ? S_FETCH : S_RTYPEEX;
                        OP_BEQ:       state_d = S_BEQEX;
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_J:         state_d = S_JEX;
                        OP_BNE:       state_d = EXT_EN ? S_BNEEX : S_TRAP;
                        OP_ANDI, OP_ORI: state_d = EXT_EN ? S_IMMEX : S_TRAP;
                        default:      state_d = S_TRAP;
                    endcase
                    trap_code_s = FC_ILL_OP;
                end
                S_MEMADR: begin
                    // Opcode is stable in the IR; anything but LW/SW here is corrupt.
                    if (bus.op == OP_LW) begin
                        state_d = S_MEMRD;
                    end else if (bus.op == OP_SW) begin
                        state_d = S_MEMWR;
                    end else begin
                        state_d = S_TRAP;
                    end
                    trap_code_s = FC_ILL_OP;
                end
                S_MEMRD:   state_d = ready_s ? S_MEMWB : S_MEMRD;
                S_MEMWR:   state_d = ready_s ? S_FETCH : S_MEMWR;
                S_RTYPEEX: begin
                    state_d     = funct_legal(bus.funct) ? S_RTYPEWB : S_TRAP;
                    trap_code_s = FC_ILL_FN;
                end
                S_MEMWB, S_RTYPEWB, S_BEQEX, S_BNEEX, S_JEX, S_ADDIWB: state_d = S_FETCH;
                S_ADDIEX, S_IMMEX: state_d = S_ADDIWB;
                S_TRAP:    state_d = S_TRAP;
                default:   state_d = S_FETCH;
            endcase
        end

        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (wait_state_s && !ready_s && (wait_cnt_q != WAIT_LIM)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        if ((state_q != S_TRAP) && (state_d == S_TRAP)) begin
            fault_code_d = trap_code_s;
        end else begin
            fault_code_d = fault_code_q;
        end
    end

    logic       memreq_s, pcen_s, memwrite_s, irwrite_s, regwrite_s;
    logic       alusrca_s, iord_s, memtoreg_s, regdst_s, immzext_s, fault_s;
    logic [1:0] alusrcb_s, pcsrc_s;
    logic [2:0] alucont_s;

    // Datapath controls decoded from the current state.
    always_comb begin
        memreq_s   = 1'b0;
        pcen_s     = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        regwrite_s = 1'b0;
        alusrca_s  = 1'b0;
        iord_s     = 1'b0;
        memtoreg_s = 1'b0;
        regdst_s   = 1'b0;
        immzext_s  = 1'b0;
        fault_s    = 1'b0;
        alusrcb_s  = 2'b00;
        pcsrc_s    = 2'b00;
        alucont_s  = ALU_AND;
        case (state_q)
            S_FETCH: begin
                memreq_s  = 1'b1;
                alusrcb_s = 2'b01;
                alucont_s = ALU_ADD;
                irwrite_s = ready_s;
                pcen_s    = ready_s;
            end
            S_DECODE: begin
                alusrcb_s = 2'b11;
                alucont_s = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                alucont_s = ALU_ADD;
            end
            S_MEMRD: begin
                memreq_s = 1'b1;
                iord_s   = 1'b1;
            end
            S_MEMWB: begin
                regwrite_s = 1'b1;
                memtoreg_s = 1'b1;
            end
            S_MEMWR: begin
                memreq_s   = 1'b1;
                iord_s     = 1'b1;
                memwrite_s = ready_s;
            end
            S_RTYPEEX: begin
                alusrca_s = 1'b1;
                alucont_s = alu_from_funct(bus.funct);
            end
            S_RTYPEWB: begin
                regwrite_s = 1'b1;
                regdst_s   = 1'b1;
            end
            S_BEQEX, S_BNEEX: begin
                alusrca_s = 1'b1;
                alucont_s = ALU_SUB;
                pcsrc_s   = 2'b01;
                pcen_s    = (state_q == S_BEQEX) ? bus.zero : ~bus.zero;
            end
            S_IMMEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                immzext_s = 1'b1;
                alucont_s = (bus.op == OP_ORI) ? ALU_OR : ALU_AND;
            end
            S_ADDIWB: begin
                regwrite_s = 1'b1;
                immzext_s  = imm_logic_s;
            end
            S_JEX: begin
                pcsrc_s = 2'b10;
                pcen_s  = 1'b1;
            end
            S_TRAP: begin
                fault_s = 1'b1;
            end
            default: begin
                fault_s = 1'b0;
            end
        endcase
    end

    // State-changing enables are held off while reset is asserted.
    assign bus.memreq     = memreq_s;
    assign bus.pcen       = pcen_s & reset;
    assign bus.memwrite   = memwrite_s & reset;
    assign bus.irwrite    = irwrite_s & reset;
    assign bus.regwrite   = regwrite_s & reset;
    assign bus.alusrca    = alusrca_s;
    assign bus.iord       = iord_s;
    assign bus.memtoreg   = memtoreg_s;
    assign bus.regdst     = regdst_s;
    assign bus.immzext    = immzext_s;
    assign bus.alusrcb    = alusrcb_s;
    assign bus.pcsrc      = pcsrc_s;
    assign bus.alucont    = alucont_s;
    assign bus.fault      = fault_s;
    assign bus.fault_code = fault_code_q;
    assign bus.state_o    = state_q;

endmodule

// File: tb/tb_mc_controller_ext.sv
// Bench for mc_controller_ext: each instruction is expanded by a
// transaction-level model into an expected per-cycle trace (states,
// controls, wait phases, traps) and compared cycle by cycle.
module tb_mc_controller_ext;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_J = 6'b000010;
    localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2, ST_MEMRD = 4'd3;
    localparam logic [3:0] ST_MEMWB = 4'd4, ST_MEMWR = 4'd5, ST_RTYPEEX = 4'd6, ST_RTYPEWB = 4'd7;
    localparam logic [3:0] ST_BEQEX = 4'd8, ST_ADDIEX = 4'd9, ST_ADDIWB = 4'd10, ST_JEX = 4'd11;
    localparam logic [3:0] ST_BNEEX = 4'd12, ST_IMMEX = 4'd13, ST_TRAP = 4'd14;
    localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010, A_SUB = 3'b110, A_SLT = 3'b111;

    typedef struct packed {
        logic       memreq, pcen, memwrite, irwrite, regwrite;
        logic       alusrca, iord, memtoreg, regdst, immzext;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucont;
        logic       fault;
        logic [1:0] fault_code;
    } outs_t;

    typedef struct packed {
        logic       rdy;
        logic [3:0] st;
        outs_t      o;
    } cyc_t;

    logic       clk = 1'b0;
    logic       reset_s = 1'b0;
    logic [5:0] op_s = 6'd0;
    logic [5:0] funct_s = 6'd0;
    logic       zero_s = 1'b0;
    logic       mem_ready_s = 1'b0;
    logic       sel = 1'b0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc_no = 0;
    int         cfg_wmax = 15;
    bit         cfg_ext = 1'b1;
    cyc_t       exp_q[$];

    logic [5:0] op_tab [10] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                6'b001000, 6'b001100, 6'b001101, 6'b000010, 6'b111111};
    logic [5:0] fn_tab [6]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};

    always #5 clk = ~clk;

    mc_controller_ext_if if_a ();
    mc_controller_ext_if if_b ();

    assign if_a.op = op_s;
    assign if_a.funct = funct_s;
    assign if_a.zero = zero_s;
    assign if_a.mem_ready = mem_ready_s;
    assign if_b.op = op_s;
    assign if_b.funct = funct_s;
    assign if_b.zero = zero_s;
    assign if_b.mem_ready = mem_ready_s;

    mc_controller_ext #(.MEM_WAIT(1), .WAIT_MAX(15), .EXT_OPS(1)) dut_a (
        .clk(clk), .reset(reset_s), .bus(if_a));
    mc_controller_ext #(.MEM_WAIT(1), .WAIT_MAX(4), .EXT_OPS(0)) dut_b (
        .clk(clk), .reset(reset_s), .bus(if_b));

    outs_t      obs_o;
    logic [3:0] obs_st;

    // Observe whichever DUT is currently under test.
    always_comb begin
        if (sel) begin
            obs_st = if_b.state_o;
            obs_o  = {if_b.memreq, if_b.pcen, if_b.memwrite, if_b.irwrite, if_b.regwrite,
                      if_b.alusrca, if_b.iord, if_b.memtoreg, if_b.regdst, if_b.immzext,
                      if_b.alusrcb, if_b.pcsrc, if_b.alucont, if_b.fault, if_b.fault_code};
        end else begin
            obs_st = if_a.state_o;
            obs_o  = {if_a.memreq, if_a.pcen, if_a.memwrite, if_a.irwrite, if_a.regwrite,
                      if_a.alusrca, if_a.iord, if_a.memtoreg, if_a.regdst, if_a.immzext,
                      if_a.alusrcb, if_a.pcsrc, if_a.alucont, if_a.fault, if_a.fault_code};
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h (dut %0d)", tag, got, exp, sel);
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic rdy, input logic [3:0] st, input outs_t o);
        cyc_t c;
        c.rdy = rdy;
        c.st  = st;
        c.o   = o;
        exp_q.push_back(c);
    endtask

    task automatic push_trap(input logic [1:0] code, input int n);
        outs_t o;
        o = '0;
        o.fault = 1'b1;
        o.fault_code = code;
        for (int i = 0; i < n; i++) push(rnd_bit(), ST_TRAP, o);
    endtask

    // n not-ready cycles then one ready cycle; the (WAIT_MAX+1)-th
    // consecutive not-ready cycle ends in a timeout instead.
    task automatic wait_phase(input logic [3:0] st, input outs_t busy, input outs_t done,
                              input int n, output bit timed_out);
        timed_out = 1'b0;
        for (int i = 0; i < n; i++) begin
            push(1'b0, st, busy);
            if (cfg_wmax != 0 && i == cfg_wmax) begin
                timed_out = 1'b1;
                return;
            end
        end
        push(1'b1, st, done);
    endtask

    task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                             input int wf, input int wm, input int ntrap, output bit trapped);
        outs_t o, r;
        bit to;
        logic [1:0] code;
        logic [2:0] rop;
        bit legal;
        trapped = 1'b0;
        code = 2'b00;
        o = '0; o.memreq = 1'b1; o.alusrcb = 2'b01; o.alucont = A_ADD;
        r = o; r.irwrite = 1'b1; r.pcen = 1'b1;
        wait_phase(ST_FETCH, o, r, wf, to);
        if (to) begin push_trap(2'b11, ntrap); trapped = 1'b1; return; end
        o = '0; o.alusrcb = 2'b11; o.alucont = A_ADD;
        push(rnd_bit(), ST_DECODE, o);
        if (!cfg_ext && (op == OP_BNE || op == OP_ANDI || op == OP_ORI)) begin
            push_trap(2'b01, ntrap); trapped = 1'b1; return;
        end
        case (op)
            OP_LW, OP_SW: begin
                o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10; o.alucont = A_ADD;
                push(rnd_bit(), ST_MEMADR, o);
                o = '0; o.memreq = 1'b1; o.iord = 1'b1;
                r = o;
                if (op == OP_SW) r.memwrite = 1'b1;
                wait_phase((op == OP_LW) ? ST_MEMRD : ST_MEMWR, o, r, wm, to);
                if (to) begin trapped = 1'b1; code = 2'b11; end
                else if (op == OP_LW) begin
                    o = '0; o.regwrite = 1'b1; o.memtoreg = 1'b1;
                    push(rnd_bit(), ST_MEMWB, o);
                end
            end
            OP_RTYPE: begin
                if (fn != 6'b000000) begin
                    legal = 1'b1;
                    case (fn)
                        6'b100000: rop = A_ADD;
                        6'b100010: rop = A_SUB;
                        6'b100100: rop = A_AND;
                        6'b100101: rop = A_OR;
                        6'b101010: rop = A_SLT;
                        default: begin rop = A_AND; legal = 1'b0; end
                    endcase
                    o = '0; o.alusrca = 1'b1; o.alucont = rop;
                    push(rnd_bit(), ST_RTYPEEX, o);
                    if (legal) begin
                        o = '0; o.regwrite = 1'b1; o.regdst = 1'b1;
                        push(rnd_bit(), ST_RTYPEWB, o);
                    end else begin
                        trapped = 1'b1; code = 2'b10;
                    end
                end
            end
            OP_BEQ, OP_BNE: begin
                o = '0; o.alusrca = 1'b1; o.alucont = A_SUB; o.pcsrc = 2'b01;
                o.pcen = (op == OP_BEQ) ? zero : ~zero;
                push(rnd_bit(), (op == OP_BEQ) ? ST_BEQEX : ST_BNEEX, o);
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10;
                o.immzext = (op != OP_ADDI);
                o.alucont = (op == OP_ADDI) ? A_ADD : ((op == OP_ORI) ? A_OR : A_AND);
                push(rnd_bit(), (op == OP_ADDI) ? ST_ADDIEX : ST_IMMEX, o);
                o = '0; o.regwrite = 1'b1; o.immzext = (op != OP_ADDI);
                push(rnd_bit(), ST_ADDIWB, o);
            end
            OP_J: begin
                o = '0; o.pcsrc = 2'b10; o.pcen = 1'b1;
                push(rnd_bit(), ST_JEX, o);
            end
            default: begin
                trapped = 1'b1; code = 2'b01;
            end
        endcase
        if (trapped) push_trap(code, ntrap);
    endtask

    task automatic run_queue();
        cyc_t c;
        while (exp_q.size() != 0) begin
            c = exp_q.pop_front();
            mem_ready_s = c.rdy;
            #1;
            check_eq($sformatf("state@%0d", cyc_no), {28'd0, obs_st}, {28'd0, c.st});
            check_eq($sformatf("outs@%0d st%0d", cyc_no, c.st), {12'd0, obs_o}, {12'd0, c.o});
            cyc_no++;
            @(posedge clk);
            #1;
        end
    endtask

    // Asynchronous reset mid-cycle: FETCH decode with all enables off.
    task automatic reset_check(input string why);
        outs_t e;
        e = '0; e.memreq = 1'b1; e.alusrcb = 2'b01; e.alucont = A_ADD;
        #1;
        mem_ready_s = 1'b1;
        reset_s = 1'b0;
        #1;
        check_eq({why, "-rst-state"}, {28'd0, obs_st}, {28'd0, ST_FETCH});
        check_eq({why, "-rst-outs"}, {12'd0, obs_o}, {12'd0, e});
        @(posedge clk);
        #1;
        check_eq({why, "-rst-hold"}, {12'd0, obs_o}, {12'd0, e});
        reset_s = 1'b1;
    endtask

    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                            input int wf, input int wm, input int ntrap);
        bit trapped;
        op_s = op;
        funct_s = fn;
        zero_s = zero;
        gen_instr(op, fn, zero, wf, wm, ntrap, trapped);
        run_queue();
        if (trapped) reset_check($sformatf("trap-op%0h", op));
    endtask

    task automatic random_instrs(input int n);
        int oi, fi, wf, wm;
        logic [5:0] op, fn;
        for (int k = 0; k < n; k++) begin
            oi = $urandom_range(0, 9);
            op = op_tab[oi];
            if (oi == 9) op = 6'($urandom_range(0, 63));
            fi = $urandom_range(0, 6);
            fn = (fi == 6) ? 6'($urandom_range(0, 63)) : fn_tab[fi];
            wf = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3);
            wm = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3);
            do_instr(op, fn, rnd_bit(), wf, wm, 3);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        sel = 1'b0; cfg_wmax = 15; cfg_ext = 1'b1;
        reset_check("init-a");
        do_instr(OP_LW, 6'd0, 1'b0, 3, 2, 0);
        do_instr(OP_BNE, 6'd0, 1'b0, 0, 0, 0);
        do_instr(OP_BNE, 6'd0, 1'b1, 1, 0, 0);
        do_instr(OP_ORI, 6'd0, 1'b0, 0, 0, 0);
        do_instr(OP_ANDI, 6'd0, 1'b1, 0, 0, 0);
        do_instr(OP_RTYPE, 6'b000000, 1'b0, 0, 0, 0);
        do_instr(OP_RTYPE, 6'b101010, 1'b0, 2, 0, 0);
        do_instr(OP_SW, 6'd0, 1'b0, 0, 1, 0);
        do_instr(OP_BEQ, 6'd0, 1'b1, 0, 0, 0);
        do_instr(OP_J, 6'd0, 1'b0, 0, 0, 0);
        do_instr(OP_ADDI, 6'd0, 1'b0, 0, 0, 0);
        do_instr(OP_RTYPE, 6'b000110, 1'b0, 0, 0, 4);
        do_instr(6'b111111, 6'd0, 1'b0, 0, 0, 20);
        do_instr(OP_LW, 6'd0, 1'b0, 0, 16, 2);
        random_instrs(80);

        sel = 1'b1; cfg_wmax = 4; cfg_ext = 1'b0;
        reset_check("init-b");
        do_instr(OP_SW, 6'd0, 1'b0, 0, 10, 5);
        do_instr(OP_BNE, 6'd0, 1'b0, 0, 0, 4);
        do_instr(OP_ORI, 6'd0, 1'b0, 0, 0, 2);
        do_instr(OP_LW, 6'd0, 1'b0, 4, 4, 0);
        do_instr(OP_ADDI, 6'd0, 1'b0, 5, 0, 2);
        random_instrs(80);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_controller_ext.md
Name: mc_controller_ext

Overview:
- Next-generation multicycle MIPS control unit: a state-machine FSM plus ALU decoder driving the existing multicycle datapath.
- Adds the following over the current controller:
  - BNE, ANDI and ORI support, with a zero-extend select.
  - A memory ready handshake with wait states.
  - A bounded wait timeout.
  - A sticky fault/trap state.
- Sits between instruction register op/funct fields and datapath mux/enable controls.

Parameters:
- MEM_WAIT, 1: 1 = FETCH/MEMRD/MEMWR hold until mem_ready; 0 = mem_ready ignored (treated as 1).
- WAIT_MAX, 15: maximum consecutive not-ready cycles before timeout trap; 0 disables timeout.
- EXT_OPS, 1: 1 = BNE/ANDI/ORI legal; 0 = those opcodes trap as illegal.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- op  in  6  instruction[31:26]
- funct  in  6  instruction[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- memreq  out  1  memory access in progress
- pcen  out  1  PC register enable
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register enable
- regwrite  out  1  register file write enable
- alusrca  out  1  0 = PC, 1 = rs register
- iord  out  1  0 = PC address, 1 = ALU-out address
- memtoreg  out  1  write-back source: 1 = memory data
- regdst  out  1  1 = rd, 0 = rt
- immzext  out  1  1 = zero-extend immediate
- alusrcb  out  2  00 = rt, 01 = constant 4, 10 = immediate, 11 = immediate<<2
- pcsrc  out  2  00 = ALU result, 01 = ALU-out, 10 = jump target
- alucont  out  3  AND=000 OR=001 ADD=010 SUB=110 SLT=111
- fault  out  1  sticky trap indicator
- fault_code  out  2  00 none, 01 illegal op, 10 illegal funct, 11 memory timeout
- state_o  out  4  current state, for debug/bench

Behaviour:
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7
  - BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, BNEEX=12, IMMEX=13, TRAP=14
  - 15 is unreachable and recovers to FETCH.
- Reset (reset low, asynchronous):
  - state=FETCH, wait counter=0, fault=0, fault_code=00.
  - While reset is low, pcen/irwrite/regwrite/memwrite are forced 0.
  - Other outputs show FETCH decode.
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000, ANDI 001100, ORI 001101, J 000010.
- Transitions:
  - FETCH -> DECODE when ready, where ready = mem_ready | ~MEM_WAIT.
  - DECODE:
    - LW/SW -> MEMADR; RTYPE -> RTYPEEX; BEQ -> BEQEX; BNE -> BNEEX.
    - ADDI -> ADDIEX; ANDI/ORI -> IMMEX; J -> JEX.
    - RTYPE with funct=000000 (nop) -> FETCH.
    - Anything else -> TRAP with code 01.
  - MEMADR: LW -> MEMRD; SW -> MEMWR.
  - MEMRD -> MEMWB when ready.
  - MEMWR -> FETCH when ready.
  - RTYPEEX -> RTYPEWB if funct is in {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt}; otherwise TRAP with code 10.
  - MEMWB, RTYPEWB, BEQEX, BNEEX, JEX, ADDIWB -> FETCH.
  - ADDIEX -> ADDIWB; IMMEX -> ADDIWB.
  - TRAP holds until reset.
- Outputs are combinational from state (and from mem_ready, zero, funct, op where noted). Unlisted outputs are 0.
  - FETCH: memreq=1, alusrcb=01, alucont=ADD, pcsrc=00, irwrite=pcen=ready.
  - DECODE: alusrcb=11, alucont=ADD.
  - MEMADR: alusrca=1, alusrcb=10, ADD.
  - MEMRD: memreq=1, iord=1.
  - MEMWB: regwrite=1, memtoreg=1.
  - MEMWR: memreq=1, iord=1, memwrite=ready.
  - RTYPEEX: alusrca=1, alusrcb=00, alucont from funct.
  - RTYPEWB: regwrite=1, regdst=1.
  - BEQEX/BNEEX: alusrca=1, SUB, pcsrc=01. pcen=zero for BEQ, ~zero for BNE.
  - ADDIEX: alusrca=1, alusrcb=10, ADD.
  - IMMEX: alusrca=1, alusrcb=10, immzext=1, alucont AND for ANDI or OR for ORI (from op).
  - ADDIWB: regwrite=1; immzext is held as in IMMEX (from op) so the write-back value is stable.
  - JEX: pcsrc=10, pcen=1.
  - TRAP: all enables 0, fault=1.
- Wait counter:
  - Increments each cycle in FETCH/MEMRD/MEMWR with ready=0.
  - Clears on any state change.
  - When it equals WAIT_MAX (WAIT_MAX>0) and ready is still 0 -> TRAP with code 11; memwrite never asserted.
- Whenever the state is TRAP, fault_code latches the cause on entry and is held.

Test Plan:
- MEM_WAIT=1, LW with mem_ready low 3 cycles in FETCH and 2 in MEMRD -> states 0,0,0,0,1,2,3,3,3,4,0; irwrite exactly 1 cycle; regwrite=1 only in MEMWB.
- BNE with zero=0 then BNE with zero=1 -> pcen=1, pcsrc=01 in BNEEX first time; pcen=0 second time; both return to FETCH.
- ORI -> IMMEX then ADDIWB; alucont=001, immzext=1, regwrite=1 in ADDIWB; ANDI gives alucont=000.
- op=111111 -> TRAP, fault=1, fault_code=01, all enables 0 for 20 cycles; reset low mid-trap -> FETCH, fault=0 immediately (asynchronous).
- RTYPE funct=000110 -> TRAP code 10. RTYPE funct=000000 -> DECODE->FETCH with no regwrite.
- WAIT_MAX=4, mem_ready held 0 in MEMWR -> TRAP code 11 after 5 MEMWR cycles, memwrite never 1. Repeat with EXT_OPS=0 and BNE -> TRAP code 01.
